// File: rtl/hdmi_audio_sample_packer.sv
// Buffers strobed 16-bit L/R audio pairs and, on scheduler request, emits one
// 2-channel layout-0 HDMI Audio Sample Packet header plus subpacket 0.
module hdmi_audio_sample_packer #(
   parameter int           FIFO_AW = 2,
   parameter logic [3:0]   CS_FS   = 4'b0010,
   parameter logic [3:0]   CS_WLEN = 4'b0010
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sample_stb,
   input  logic [15:0]        in_l,
   input  logic [15:0]        in_r,
   input  logic               mute,
   input  logic               pkt_req,
   output logic               pkt_valid,
   output logic [23:0]        pkt_hb,
   output logic [55:0]        pkt_sp0,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow
);

   localparam logic [FIFO_AW:0] DEPTH_L = {1'b1, {FIFO_AW{1'b0}}};
   localparam int               DEPTH   = 2**FIFO_AW;

   logic [31:0]          mem_q [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]     level_q, level_d;
   logic [7:0]           fc_q, fc_d;
   logic                 ovf_q, ovf_d;
   logic                 valid_q;
   logic [23:0]          hb_q, hb_d;
   logic [55:0]          sp0_q, sp0_d;

   logic                 full, empty, push, pop;
   logic [191:0]         cs_vec;
   logic                 c_bit, p_l, p_r;
   logic [31:0]          head;
   logic [23:0]          l24, r24;
   logic [7:0]           hb2;

   assign full  = (level_q == DEPTH_L);
   assign empty = (level_q == '0);
   assign pop   = pkt_req && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push  = sample_stb && (!full || pop);

   always_comb begin
      cs_vec        = '0;
      cs_vec[2]     = 1'b1;
      cs_vec[27:24] = CS_FS;
      cs_vec[35:32] = CS_WLEN;
   end

   assign c_bit = cs_vec[fc_q];
   assign head  = mem_q[rd_ptr_q];
   assign l24   = mute ? 24'h0 : {head[31:16], 8'h00};
   assign r24   = mute ? 24'h0 : {head[15:0], 8'h00};
   // Even parity over sample, V, U, C; V and U are always zero.
   assign p_l   = ^{l24, c_bit};
   assign p_r   = ^{r24, c_bit};
   assign hb2   = {3'b000, (fc_q == 8'd0), 3'b000, mute};

   always_comb begin
      hb_d     = hb_q;
      sp0_d    = sp0_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fc_d     = fc_q;
      ovf_d    = ovf_q || (sample_stb && full && !pop);
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop) begin
         rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
         fc_d     = (fc_q == 8'd191) ? 8'd0 : fc_q + 8'd1;
         hb_d     = {hb2, 8'h01, 8'h02};
         sp0_d    = {p_r, c_bit, 1'b0, 1'b0, p_l, c_bit, 1'b0, 1'b0, r24, l24};
      end
      case ({push, pop})
         2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
         2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_l, in_r};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         fc_q     <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         hb_q     <= '0;
         sp0_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         fc_q     <= fc_d;
         ovf_q    <= ovf_d;
         valid_q  <= pop;
         hb_q     <= hb_d;
         sp0_q    <= sp0_d;
      end
   end

   assign pkt_valid  = valid_q;
   assign pkt_hb     = hb_q;
   assign pkt_sp0    = sp0_q;
   assign fifo_level = level_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_hdmi_audio_sample_packer.sv
// Directed bench for hdmi_audio_sample_packer: a vector table for the basic
// push/pop/overflow flow plus hand-written multi-cycle sequences.
module tb_hdmi_audio_sample_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_stb;
   logic [15:0] in_l, in_r;
   logic        mute;
   logic        pkt_req;
   logic        pkt_valid;
   logic [23:0] pkt_hb;
   logic [55:0] pkt_sp0;
   logic [2:0]  fifo_level;
   logic        overflow;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   hdmi_audio_sample_packer #(.FIFO_AW(2), .CS_FS(4'b0010), .CS_WLEN(4'b0010)) dut (
      .clk(clk), .reset(reset), .sample_stb(sample_stb), .in_l(in_l), .in_r(in_r),
      .mute(mute), .pkt_req(pkt_req), .pkt_valid(pkt_valid), .pkt_hb(pkt_hb),
      .pkt_sp0(pkt_sp0), .fifo_level(fifo_level), .overflow(overflow)
   );

   typedef struct {
      logic        stb;
      logic [15:0] l;
      logic [15:0] r;
      logic        m;
      logic        req;
      logic        e_valid;
      logic [23:0] e_hb;
      logic [55:0] e_sp0;
      logic [2:0]  e_level;
      logic        e_ovf;
   } vec_t;

   vec_t vq[$];

   // Channel status with 48 kHz / 16-bit codes has ones only at bits 2, 25, 33.
   function automatic logic c_of(input int fc);
      return (fc == 2) || (fc == 25) || (fc == 33);
   endfunction

   function automatic logic [23:0] model_hb(input int fc, input logic m);
      return {3'b000, (fc == 0), 3'b000, m, 8'h01, 8'h02};
   endfunction

   function automatic logic [55:0] model_sp0(input logic [15:0] l, input logic [15:0] r,
                                             input logic m, input int fc);
      logic [23:0] l24, r24;
      logic        c, pl, pr;
      c   = c_of(fc);
      l24 = m ? 24'h0 : {l, 8'h00};
      r24 = m ? 24'h0 : {r, 8'h00};
      pl  = (^l24) ^ c;
      pr  = (^r24) ^ c;
      return {pr, c, 2'b00, pl, c, 2'b00, r24, l24};
   endfunction

   function automatic vec_t mk(input logic stb, input logic [15:0] l, input logic [15:0] r,
                               input logic m, input logic req, input logic ev,
                               input logic [23:0] ehb, input logic [55:0] esp,
                               input logic [2:0] elev, input logic eovf);
      vec_t v;
      v.stb = stb; v.l = l; v.r = r; v.m = m; v.req = req;
      v.e_valid = ev; v.e_hb = ehb; v.e_sp0 = esp; v.e_level = elev; v.e_ovf = eovf;
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic stb, input logic [15:0] l, input logic [15:0] r,
                       input logic m, input logic req);
      sample_stb = stb; in_l = l; in_r = r; mute = m; pkt_req = req;
      @(posedge clk);
      #1;
      sample_stb = 1'b0; pkt_req = 1'b0; mute = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; sample_stb = 1'b0; in_l = '0; in_r = '0; mute = 1'b0; pkt_req = 1'b0;
      do_reset();
      check("reset_valid", 64'(pkt_valid), 64'd0);
      check("reset_hb", 64'(pkt_hb), 64'd0);
      check("reset_sp0", 64'(pkt_sp0), 64'd0);
      check("reset_level", 64'(fifo_level), 64'd0);
      check("reset_ovf", 64'(overflow), 64'd0);

      vq.push_back(mk(1, 16'h1234, 16'hABCD, 0, 0, 0, 0, 0, 3'd1, 0));
      vq.push_back(mk(0, 0, 0, 0, 1, 1, 24'h100102, 56'h08ABCD00123400, 3'd0, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0));
      for (int i = 1; i <= 5; i++)
         vq.push_back(mk(1, 16'(i), 16'(16'h1000 + i), 0, 0, 0, 0, 0,
                         (i > 4) ? 3'd4 : 3'(i), (i == 5)));
      for (int i = 1; i <= 4; i++)
         vq.push_back(mk(0, 0, 0, 0, 1, 1, model_hb(i, 0),
                         model_sp0(16'(i), 16'(16'h1000 + i), 0, i), 3'(4 - i), 1));
      vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 3'd0, 1));
      vq.push_back(mk(1, 16'h5555, 16'h0F0F, 0, 1, 0, 0, 0, 3'd1, 1));
      vq.push_back(mk(0, 0, 0, 0, 1, 1, model_hb(5, 0),
                      model_sp0(16'h5555, 16'h0F0F, 0, 5), 3'd0, 1));

      for (int k = 0; k < vq.size(); k++) begin
         step(vq[k].stb, vq[k].l, vq[k].r, vq[k].m, vq[k].req);
         check($sformatf("vec%0d_valid", k), 64'(pkt_valid), 64'(vq[k].e_valid));
         check($sformatf("vec%0d_level", k), 64'(fifo_level), 64'(vq[k].e_level));
         check($sformatf("vec%0d_ovf", k), 64'(overflow), 64'(vq[k].e_ovf));
         if (vq[k].e_valid) begin
            check($sformatf("vec%0d_hb", k), 64'(pkt_hb), 64'(vq[k].e_hb));
            check($sformatf("vec%0d_sp0", k), 64'(pkt_sp0), 64'(vq[k].e_sp0));
         end
      end

      // Mute at pop: flat samples, parity carries only C (zero at fc=0).
      do_reset();
      step(1, 16'h7FFF, 16'h0001, 0, 0);
      step(0, 0, 0, 1, 1);
      check("mute_valid", 64'(pkt_valid), 64'd1);
      check("mute_hb", 64'(pkt_hb), 64'h110102);
      check("mute_sp0", 64'(pkt_sp0), 64'd0);

      // Full FIFO with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 16'(16'h0100 + i), 16'(16'h0200 + i), 0, 0);
      step(1, 16'hBEEF, 16'h0042, 0, 1);
      check("full_sim_valid", 64'(pkt_valid), 64'd1);
      check("full_sim_sp0", 64'(pkt_sp0), 64'(model_sp0(16'h0100, 16'h0200, 0, 0)));
      check("full_sim_level", 64'(fifo_level), 64'd4);
      check("full_sim_ovf", 64'(overflow), 64'd0);
      for (int i = 1; i < 4; i++) step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check("full_sim_newest", 64'(pkt_sp0), 64'(model_sp0(16'hBEEF, 16'h0042, 0, 4)));
      check("full_sim_drained", 64'(fifo_level), 64'd0);

      // Reset while a packet is being presented and overflow is set.
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 16'hFFFF, 16'h8001, 0, 0);
      step(0, 0, 0, 0, 1);
      check("pre_rst_valid", 64'(pkt_valid), 64'd1);
      check("pre_rst_ovf", 64'(overflow), 64'd1);
      reset = 1'b1;
      step(1, 16'h1111, 16'h2222, 0, 1);
      reset = 1'b0;
      check("mid_rst_valid", 64'(pkt_valid), 64'd0);
      check("mid_rst_hb", 64'(pkt_hb), 64'd0);
      check("mid_rst_sp0", 64'(pkt_sp0), 64'd0);
      check("mid_rst_level", 64'(fifo_level), 64'd0);
      check("mid_rst_ovf", 64'(overflow), 64'd0);

      // 193 packets: block-start flag and channel-status walk with wrap.
      do_reset();
      for (int k = 0; k < 193; k++) begin
         logic [15:0] l, r;
         l = 16'(k * 16'h0101 + 3);
         r = 16'(16'hA000 ^ k);
         step(1, l, r, 0, 0);
         step(0, 0, 0, 0, 1);
         check($sformatf("fc%0d_valid", k), 64'(pkt_valid), 64'd1);
         check($sformatf("fc%0d_bflag", k), 64'(pkt_hb[20]), 64'((k == 0) || (k == 192)));
         check($sformatf("fc%0d_cbit", k), 64'(pkt_sp0[50]), 64'((k == 2) || (k == 25) || (k == 33)));
         check($sformatf("fc%0d_sp0", k), 64'(pkt_sp0), 64'(model_sp0(l, r, 0, k % 192)));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
